// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, oversampling ratio and
// line-control character-length helpers.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Character length in bits (5..8) for a line-control wls field.
    function automatic logic [3:0] char_len(input logic [1:0] wls);
        return 4'd5 + {2'b00, wls};
    endfunction

endpackage

// File: rtl/dff.sv
// Generic synchronous-reset register used for FSM state storage.
module dff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_transmit_shift.sv
// Transmit datapath: character shift register, data-bit counter and parity
// generator, all loaded together when the FSM accepts a character.
module uart_transmit_shift
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_wls,
    input  logic                  i_eps,
    output logic                  o_bit0,
    output logic                  o_bit1,
    output logic                  o_last_bit,
    output logic                  o_parity
);

    logic [DATA_WIDTH-1:0] r_shreg;
    logic [2:0]            r_bit_cnt;
    logic [1:0]            r_wls;
    logic                  r_parity;
    logic                  w_xor;

    // Only the bits inside the selected character length feed parity.
    always_comb begin
        w_xor = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < int'(char_len(i_wls))) begin
                w_xor = w_xor ^ i_data[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_wls     <= WLS_5;
            r_parity  <= 1'b0;
        end else if (i_load) begin
            r_shreg   <= i_data;
            r_bit_cnt <= '0;
            r_wls     <= i_wls;
            r_parity  <= i_eps ? w_xor : ~w_xor;
        end else if (i_shift) begin
            r_shreg   <= r_shreg >> 1;
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    assign o_bit0     = r_shreg[0];
    assign o_bit1     = r_shreg[1];
    assign o_last_bit = ({1'b0, r_bit_cnt} == (char_len(r_wls) - 4'd1));
    assign o_parity   = r_parity;

endmodule

// File: rtl/uart_transmit_fsm.sv
// UART transmitter: accepts a character over valid/ready and serializes it as
// start, 5-8 data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_transmit_fsm
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  uttren,
    input  logic                  baud_tick,
    input  logic [1:0]            wls,
    input  logic                  pen,
    input  logic                  eps,
    input  logic                  stb,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  uart_txd,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic [2:0]            dbg_state
);

    localparam int CNT_W = $clog2(OVERSAMPLE);

    logic [2:0]       w_state_q;
    logic [2:0]       w_state_d;
    tx_state_e        w_state;
    tx_state_e        w_state_next;
    logic             w_accept;
    logic             w_bit_end;
    logic             w_shift;
    logic             w_bit0;
    logic             w_bit1;
    logic             w_last_bit;
    logic             w_parity;
    logic             w_stop_last;
    logic             w_txd_next;

    logic [CNT_W-1:0] r_tick_cnt;
    logic             r_pen;
    logic             r_stb;
    logic             r_stop_cnt;
    logic             r_txd;
    logic             r_done;

    // Handshake: a character transfers on any cycle where tx_valid and
    // tx_ready are both high; tx_ready depends only on state, uttren and
    // preset (never on tx_valid), and tx_data must be stable while valid.
    assign tx_ready  = (w_state == IDLE) && uttren && !preset;
    assign w_accept  = tx_valid && tx_ready;
    assign w_bit_end = baud_tick && (r_tick_cnt == CNT_W'(OVERSAMPLE - 1));
    assign w_shift   = uttren && (w_state == DATA) && w_bit_end;
    assign w_stop_last = w_bit_end && (!r_stb || r_stop_cnt);

    assign w_state   = tx_state_e'(w_state_q);
    assign w_state_d = w_state_next;

    dff #(
        .WIDTH     (3),
        .RESET_VAL (IDLE)
    ) u_state_ff (
        .i_clk (pclk),
        .i_rst (preset),
        .i_d   (w_state_d),
        .o_q   (w_state_q)
    );

    uart_transmit_shift #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .i_clk      (pclk),
        .i_rst      (preset),
        .i_load     (w_accept),
        .i_shift    (w_shift),
        .i_data     (tx_data),
        .i_wls      (wls),
        .i_eps      (eps),
        .o_bit0     (w_bit0),
        .o_bit1     (w_bit1),
        .o_last_bit (w_last_bit),
        .o_parity   (w_parity)
    );

    always_comb begin
        w_state_next = w_state;
        if (!uttren) begin
            w_state_next = IDLE;
        end else begin
            case (w_state)
                IDLE:    if (w_accept) w_state_next = START;
                START:   if (w_bit_end) w_state_next = DATA;
                DATA:    if (w_bit_end && w_last_bit) w_state_next = r_pen ? PARITY : STOP;
                PARITY:  if (w_bit_end) w_state_next = STOP;
                STOP:    if (w_stop_last) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // The line is registered, so it is driven from the state being entered.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            START:   w_txd_next = 1'b0;
            DATA:    w_txd_next = w_shift ? w_bit1 : w_bit0;
            PARITY:  w_txd_next = w_parity;
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_tick_cnt <= '0;
            r_pen      <= 1'b0;
            r_stb      <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_txd      <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_txd  <= w_txd_next;
            r_done <= uttren && (w_state == STOP) && w_stop_last;

            if (w_accept || !uttren || (w_state == IDLE)) begin
                r_tick_cnt <= '0;
            end else if (baud_tick) begin
                r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + CNT_W'(1);
            end

            if (w_accept) begin
                r_pen      <= pen;
                r_stb      <= stb;
                r_stop_cnt <= 1'b0;
            end else if ((w_state == STOP) && w_bit_end) begin
                r_stop_cnt <= 1'b1;
            end
        end
    end

    assign uart_txd  = r_txd;
    assign tx_done   = r_done;
    assign tx_busy   = (w_state != IDLE);
    assign dbg_state = w_state_q;

endmodule

// File: tb/tb_uart_transmit_fsm.sv
// Bench for uart_transmit_fsm: directed and random frames compared bit by
// bit against a frame model built from the line-control settings.
module tb_uart_transmit_fsm;
    import uart_pkg::*;

    logic       pclk = 1'b0;
    logic       preset;
    logic       uttren;
    logic       baud_tick;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       stb;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] dbg_state;

    int n_chk  = 0;
    int n_fail = 0;
    int tick_mode = 0;
    logic [0:0] exp_q[$];

    uart_transmit_fsm #(
        .OVERSAMPLE (16),
        .DATA_WIDTH (8)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .uttren    (uttren),
        .baud_tick (baud_tick),
        .wls       (wls),
        .pen       (pen),
        .eps       (eps),
        .stb       (stb),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .dbg_state (dbg_state)
    );

    always #5 pclk = ~pclk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_tick();
        if (tick_mode == 0) baud_tick = 1'b1;
        else baud_tick = ($urandom_range(0, 2) == 0);
    endtask

    // Expected line levels of one frame, one entry per bit period.
    task automatic build_frame(input logic [7:0] d, input logic [1:0] w,
                               input logic p, input logic e, input logic s);
        int   n;
        int   ones;
        logic par;
        n    = int'(w) + 5;
        ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (p) begin
            par = ((ones % 2) == 1);
            if (!e) par = ~par;
            exp_q.push_back(par);
        end
        exp_q.push_back(1'b1);
        if (s) exp_q.push_back(1'b1);
    endtask

    task automatic idle(input int n);
        tx_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            set_tick();
            @(posedge pclk); #1;
            chk("idle_txd", uart_txd, 1);
            chk("idle_busy", tx_busy, 0);
            chk("idle_done", tx_done, 0);
        end
    endtask

    // abort_kind: 0 none, 1 drop uttren, 2 assert preset (in 3rd data bit).
    task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic p,
                              input logic e, input logic s, input int hold,
                              input int scramble, input int abort_kind);
        int   k;
        int   t;
        int   edges;
        logic tk;
        build_frame(d, w, p, e, s);
        tx_data  = d;
        wls      = w;
        pen      = p;
        eps      = e;
        stb      = s;
        tx_valid = 1'b1;
        set_tick();
        #1;
        chk("ready_at_accept", tx_ready, 1);
        @(posedge pclk); #1;
        if (hold == 0) tx_valid = 1'b0;
        k = 0;
        t = 0;
        edges = 0;
        while (k < exp_q.size() && edges < 6000) begin
            chk("txd_bit", uart_txd, exp_q[k]);
            chk("busy_frame", tx_busy, 1);
            chk("done_low", tx_done, 0);
            chk("ready_low", tx_ready, 0);
            if (scramble != 0 && k == 2) begin
                wls     = 2'($urandom);
                pen     = 1'($urandom);
                eps     = 1'($urandom);
                stb     = 1'($urandom);
                tx_data = 8'($urandom);
            end
            if (abort_kind != 0 && k == 3 && t == 2) begin
                if (abort_kind == 1) uttren = 1'b0;
                else preset = 1'b1;
                @(posedge pclk); #1;
                chk("abort_state", dbg_state, IDLE);
                chk("abort_txd", uart_txd, 1);
                chk("abort_busy", tx_busy, 0);
                chk("abort_done", tx_done, 0);
                chk("abort_ready", tx_ready, 0);
                for (int i = 0; i < 3; i++) begin
                    set_tick();
                    @(posedge pclk); #1;
                    chk("abort_done_after", tx_done, 0);
                    chk("abort_txd_after", uart_txd, 1);
                    chk("abort_busy_after", tx_busy, 0);
                end
                uttren = 1'b1;
                preset = 1'b0;
                return;
            end
            set_tick();
            tk = baud_tick;
            @(posedge pclk); #1;
            edges++;
            if (tk) begin
                t++;
                if (t == 16) begin
                    t = 0;
                    k++;
                end
            end
        end
        chk("frame_complete", k, exp_q.size());
        chk("done_pulse", tx_done, 1);
        chk("done_busy", tx_busy, 0);
        chk("done_txd", uart_txd, 1);
        chk("done_ready", tx_ready, 1);
        chk("done_state", dbg_state, IDLE);
        if (tick_mode == 0) chk("frame_cycles", edges, 16 * exp_q.size());
    endtask

    initial begin
        preset    = 1'b1;
        uttren    = 1'b1;
        tx_valid  = 1'b1;
        baud_tick = 1'b0;
        wls       = WLS_8;
        pen       = 1'b0;
        eps       = 1'b0;
        stb       = 1'b0;
        tx_data   = 8'h00;

        repeat (3) @(posedge pclk);
        #1;
        chk("reset_txd", uart_txd, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_done", tx_done, 0);
        chk("reset_state", dbg_state, IDLE);
        chk("reset_ready", tx_ready, 0);
        preset   = 1'b0;
        tx_valid = 1'b0;
        #1;
        chk("ready_after_reset", tx_ready, 1);
        idle(2);

        // Tick every cycle: exact frame timing.
        tick_mode = 0;
        send_frame(8'hA5, WLS_8, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        idle(3);
        send_frame(8'hA5, WLS_8, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        idle(2);
        send_frame(8'hA5, WLS_8, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(2);
        send_frame(8'hFF, WLS_5, 1'b1, 1'b1, 1'b1, 0, 0, 0);
        idle(2);

        // Back-to-back with tx_valid held, sparse ticks.
        tick_mode = 1;
        send_frame(8'h3C, WLS_7, 1'b0, 1'b0, 1'b1, 1, 0, 0);
        send_frame(8'hC3, WLS_6, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(2);

        // Transmit disabled: no handshake.
        uttren   = 1'b0;
        tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_tick();
            @(posedge pclk); #1;
            chk("disabled_ready", tx_ready, 0);
            chk("disabled_busy", tx_busy, 0);
            chk("disabled_txd", uart_txd, 1);
        end
        tx_valid = 1'b0;
        uttren   = 1'b1;
        idle(2);

        // Aborts in the 3rd data bit.
        send_frame(8'h5A, WLS_8, 1'b1, 1'b1, 1'b0, 0, 0, 1);
        idle(2);
        send_frame(8'h96, WLS_8, 1'b0, 1'b0, 1'b1, 0, 0, 2);
        idle(2);

        // Mid-frame config change, then a frame using the changed values.
        send_frame(8'h81, WLS_8, 1'b0, 1'b0, 1'b0, 0, 1, 0);
        send_frame(tx_data, wls, pen, eps, stb, 0, 0, 0);
        idle(1);

        for (int n = 0; n < 10; n++) begin
            send_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 0, 0, 0);
            idle($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
